// File: rtl/local_flit_sink.sv
// Ejection-side network interface: accepts flits from a router LOCAL port,
// buffers them for the PE, checks packet framing/destination and keeps statistics.
module local_flit_sink #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int XADDR  = 0,
  parameter int YADDR  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLIT_W-1:0] i_flit,
  input  logic              i_rec_req,
  output logic              o_rec_ack,
  output logic [FLIT_W-1:0] o_pe_flit,
  output logic              o_pe_valid,
  input  logic              i_pe_ready,
  output logic              o_pkt_done,
  output logic [7:0]        o_pkt_len,
  output logic [7:0]        o_last_src,
  output logic [15:0]       o_pkt_count,
  output logic [15:0]       o_flit_count,
  output logic [7:0]        o_err_count,
  output logic [1:0]        o_err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [3:0] MY_X = 4'(XADDR);
  localparam logic [3:0] MY_Y = 4'(YADDR);

  typedef enum logic { IDLE, IN_PKT } state_t;
  typedef enum logic [1:0] { T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11 } ftype_t;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_next;
  logic              push, pop;

  state_t     state, next_state;
  ftype_t     ftype;
  logic [7:0] len, next_len, done_len;
  logic       complete, err_hit, dest_ok;
  logic [1:0] err_val;

  assign push       = i_rec_req && o_rec_ack;
  assign pop        = o_pe_valid && i_pe_ready;
  assign o_pe_valid = (count != '0);
  assign o_pe_flit  = o_pe_valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= i_flit;
  end

  // The ack flop looks at next occupancy so it never admits a flit into a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_rec_ack <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      o_rec_ack <= (count_next < FULL);
    end
  end

  assign ftype   = ftype_t'(i_flit[FLIT_W-1 -: 2]);
  assign dest_ok = (i_flit[FLIT_W-3 -: 4] == MY_X) && (i_flit[FLIT_W-7 -: 4] == MY_Y);

  // An unexpected head outranks a wrong destination so each flit logs one error.
  always_comb begin
    next_state = state;
    next_len   = len;
    done_len   = len;
    complete   = 1'b0;
    err_hit    = 1'b0;
    err_val    = 2'b00;
    unique case (ftype)
      T_HEAD, T_SINGLE: begin
        next_len = 8'd1;
        if (ftype == T_HEAD) begin
          next_state = IN_PKT;
        end else begin
          next_state = IDLE;
          complete   = 1'b1;
          done_len   = 8'd1;
        end
        if (state == IN_PKT) begin
          err_hit = 1'b1;
          err_val = 2'b01;
        end else if (!dest_ok) begin
          err_hit = 1'b1;
          err_val = 2'b11;
        end
      end
      T_BODY, T_TAIL: begin
        if (state == IN_PKT) begin
          next_len = (len == 8'hFF) ? len : len + 8'd1;
          if (ftype == T_TAIL) begin
            next_state = IDLE;
            complete   = 1'b1;
            done_len   = next_len;
          end
        end else begin
          err_hit = 1'b1;
          err_val = 2'b10;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      len          <= '0;
      o_pkt_done   <= 1'b0;
      o_pkt_len    <= '0;
      o_last_src   <= '0;
      o_pkt_count  <= '0;
      o_flit_count <= '0;
      o_err_count  <= '0;
      o_err_code   <= '0;
    end else begin
      o_pkt_done <= 1'b0;
      if (push) begin
        state <= next_state;
        len   <= next_len;
        if (!(&o_flit_count)) o_flit_count <= o_flit_count + 16'd1;
        if (ftype == T_HEAD || ftype == T_SINGLE)
          o_last_src <= {i_flit[FLIT_W-11 -: 4], i_flit[FLIT_W-15 -: 4]};
        if (complete) begin
          o_pkt_done <= 1'b1;
          o_pkt_len  <= done_len;
          if (!(&o_pkt_count)) o_pkt_count <= o_pkt_count + 16'd1;
        end
        if (err_hit) begin
          o_err_code <= err_val;
          if (!(&o_err_count)) o_err_count <= o_err_count + 8'd1;
        end
      end
    end
  end

endmodule
